// File: rtl/count_mon_pkg.sv
// count_mon_pkg
//   Shared types and default sizes for the count threshold monitor.
//   state_e    : monitor FSM states (encoding is visible on o_state).
//   cmp_mode_e : compare modes (encoding is visible on i_cmp_mode).
package count_mon_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned EPOCH_W_DEF = 16;
  localparam int unsigned MISS_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    FIRED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    EQ    = 2'b00,
    GE    = 2'b01,
    LE    = 2'b10,
    CROSS = 2'b11
  } cmp_mode_e;

endpackage

// File: rtl/count_cmp_unit.sv
// count_cmp_unit
//   Combinational threshold compare on the registered counter sample.
//   Ports:
//     i_count    : current registered count sample
//     i_prev     : previous registered count sample
//     i_prev_vld : i_prev belongs to the current armed window
//     i_cmp      : threshold
//     i_mode     : compare mode
//     i_wrap     : ovf/udf seen with this sample; suppresses any match
//     o_match    : compare result
module count_cmp_unit
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_prev,
  input  logic             i_prev_vld,
  input  logic [WIDTH-1:0] i_cmp,
  input  cmp_mode_e        i_mode,
  input  logic             i_wrap,
  output logic             o_match
);

  logic raw_match;
  logic cross_up;
  logic cross_dn;

  assign cross_up = (i_prev < i_cmp) && (i_count >= i_cmp);
  assign cross_dn = (i_prev > i_cmp) && (i_count <= i_cmp);

  always_comb begin
    raw_match = 1'b0;
    unique case (i_mode)
      EQ:    raw_match = (i_count == i_cmp);
      GE:    raw_match = (i_count >= i_cmp);
      LE:    raw_match = (i_count <= i_cmp);
      CROSS: raw_match = i_prev_vld && (cross_up || cross_dn);
      default: raw_match = 1'b0;
    endcase
  end

  // A wrap makes the count jump across the whole range; never treat it as a hit.
  assign o_match = raw_match && !i_wrap;

endmodule

// File: rtl/count_threshold_monitor.sv
// count_threshold_monitor
//   Samples an up/down counter, tracks a signed wrap epoch, compares the
//   count against an armed threshold and raises a level interrupt.
//
//   state | meaning
//   IDLE  | no compare active, o_irq low
//   ARMED | threshold captured, waiting for a match
//   FIRED | match seen, o_irq high until acknowledged
//
//   Ports:
//     i_clk, i_rst_n          : clock, async active-low reset
//     i_count, i_ovf, i_udf   : counter value and wrap pulses
//     i_arm, i_disarm         : arm with i_cmp_val/i_cmp_mode, abandon arm
//     i_cmp_val, i_cmp_mode   : threshold and compare mode
//     i_ack                   : interrupt acknowledge
//     o_irq, o_state          : interrupt level, FSM state
//     o_epoch                 : signed wrap epoch
//     o_hit_count             : count captured on fire
//     o_miss                  : saturating matches seen while FIRED
//     o_err                   : sticky protocol error
module count_threshold_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned EPOCH_W = EPOCH_W_DEF,
  parameter int unsigned MISS_W  = MISS_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [WIDTH-1:0]   i_count,
  input  logic               i_ovf,
  input  logic               i_udf,
  input  logic               i_arm,
  input  logic               i_disarm,
  input  logic [WIDTH-1:0]   i_cmp_val,
  input  logic [1:0]         i_cmp_mode,
  input  logic               i_ack,
  output logic               o_irq,
  output logic [1:0]         o_state,
  output logic [EPOCH_W-1:0] o_epoch,
  output logic [WIDTH-1:0]   o_hit_count,
  output logic [MISS_W-1:0]  o_miss,
  output logic               o_err
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, prev_q;
  logic               ovf_q, udf_q;
  logic               prev_vld_q, prev_vld_d;
  logic [WIDTH-1:0]   cmp_q, cmp_d;
  cmp_mode_e          mode_q, mode_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [WIDTH-1:0]   hit_q, hit_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               err_q, err_d;
  logic               irq_q;
  logic               match;
  logic               arm_ok;

  count_cmp_unit #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .i_count    (count_q),
    .i_prev     (prev_q),
    .i_prev_vld (prev_vld_q),
    .i_cmp      (cmp_q),
    .i_mode     (mode_q),
    .i_wrap     (ovf_q | udf_q),
    .o_match    (match)
  );

  always_comb begin
    state_d    = state_q;
    prev_vld_d = prev_vld_q;
    cmp_d      = cmp_q;
    mode_d     = mode_q;
    epoch_d    = epoch_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    err_d      = err_q;
    arm_ok     = 1'b0;

    if (ovf_q && udf_q) begin
      err_d = 1'b1;
    end else if (ovf_q) begin
      epoch_d = epoch_q + EPOCH_W'(1);
    end else if (udf_q) begin
      epoch_d = epoch_q - EPOCH_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (i_ack) begin
          err_d = 1'b1;
        end
        if (i_arm) begin
          arm_ok  = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (i_disarm) begin
          state_d = IDLE;
        end else if (i_arm) begin
          arm_ok = 1'b1;
        end else if (match) begin
          state_d = FIRED;
          hit_d   = count_q;
        end
      end
      FIRED: begin
        if (match && (miss_q != '1)) begin
          miss_d = miss_q + MISS_W'(1);
        end
        if (i_ack && i_arm) begin
          arm_ok  = 1'b1;
          state_d = ARMED;
        end else if (i_ack) begin
          state_d = IDLE;
        end else if (i_arm) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // prev_q only becomes meaningful once one sample has been seen after arming.
    if (arm_ok) begin
      prev_vld_d = 1'b0;
      cmp_d      = i_cmp_val;
      mode_d     = cmp_mode_e'(i_cmp_mode);
      miss_d     = '0;
    end else if (state_q == ARMED) begin
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      prev_q     <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      prev_vld_q <= 1'b0;
      cmp_q      <= '0;
      mode_q     <= EQ;
      epoch_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= i_count;
      prev_q     <= count_q;
      ovf_q      <= i_ovf;
      udf_q      <= i_udf;
      prev_vld_q <= prev_vld_d;
      cmp_q      <= cmp_d;
      mode_q     <= mode_d;
      epoch_q    <= epoch_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
      irq_q      <= (state_d == FIRED);
    end
  end

  assign o_irq       = irq_q;
  assign o_state     = state_q;
  assign o_epoch     = epoch_q;
  assign o_hit_count = hit_q;
  assign o_miss      = miss_q;
  assign o_err       = err_q;

endmodule
